// File: rtl/mem_dump_pkg.sv
// Shared types and ASCII constants for the bit-memory dump streamer.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LAT,
    S_LOAD,
    S_SEND,
    S_CR,
    S_LF,
    S_FIN
  } state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  function automatic logic [7:0] ascii_bit(input logic b);
    return b ? CH_1 : CH_0;
  endfunction

endpackage

// File: rtl/mem_dump_streamer.sv
// Streams a range of a synchronous-read bit memory as ASCII '0'/'1' characters
// over a byte handshake, breaking lines with CR LF every LINE_LEN characters.
module mem_dump_streamer
  import mem_dump_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned LINE_LEN = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W:0]   i_count,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_we,
  input  logic              i_tx_wait,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [7:0]  LINE_END = 8'(LINE_LEN);

  state_t              r_state,    w_state;
  logic [ADDR_W-1:0]   r_addr,     w_addr;
  logic [CNT_W-1:0]    r_remain,   w_remain;
  logic [7:0]          r_col,      w_col;
  logic [DATA_W-1:0]   r_shift,    w_shift;
  logic [BIT_W-1:0]    r_bits,     w_bits;
  logic [7:0]          r_tx_data,  w_tx_data;
  logic                r_tx_we,    w_tx_we;
  logic                r_busy,     w_busy;
  logic                r_done,     w_done;
  logic                r_mem_rd_en, w_mem_rd_en;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic                w_accept;
  logic                w_word_end;

  // Next-state and next-output logic; byte states insert one idle cycle
  // before raising tx_we so the transmitter always gets a gap between bytes.
  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_remain    = r_remain;
    w_col       = r_col;
    w_shift     = r_shift;
    w_bits      = r_bits;
    w_tx_data   = r_tx_data;
    w_tx_we     = r_tx_we;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_accept    = r_tx_we & ~i_tx_wait;
    w_word_end  = (r_bits == BIT_W'(1));

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_addr   = i_start_addr;
          w_remain = i_count;
          w_col    = '0;
          w_busy   = 1'b1;
          w_state  = (i_count == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: w_state = S_LAT;
      S_LAT:  w_state = S_LOAD;
      S_LOAD: begin
        w_shift = i_mem_rdata;
        w_bits  = BIT_W'(DATA_W);
        w_state = S_SEND;
      end
      S_SEND: begin
        if (!r_tx_we) begin
          w_tx_we   = 1'b1;
          w_tx_data = ascii_bit(r_shift[DATA_W-1]);
        end else if (w_accept) begin
          w_tx_we = 1'b0;
          w_col   = r_col + 8'd1;
          w_bits  = r_bits - BIT_W'(1);
          w_shift = r_shift << 1;
          if (w_word_end) begin
            w_addr   = r_addr + ADDR_W'(1);
            w_remain = r_remain - CNT_W'(1);
          end
          // A full line takes priority; LF then decides whether anything is left.
          if (w_col == LINE_END) begin
            w_col   = '0;
            w_state = S_CR;
          end else if (w_word_end) begin
            w_state = (w_remain == '0) ? S_CR : S_READ;
          end
        end
      end
      S_CR: begin
        if (!r_tx_we) begin
          w_tx_we   = 1'b1;
          w_tx_data = CH_CR;
        end else if (w_accept) begin
          w_tx_we = 1'b0;
          w_state = S_LF;
        end
      end
      S_LF: begin
        if (!r_tx_we) begin
          w_tx_we   = 1'b1;
          w_tx_data = CH_LF;
        end else if (w_accept) begin
          w_tx_we = 1'b0;
          if (r_bits != '0)        w_state = S_SEND;
          else if (r_remain != '0) w_state = S_READ;
          else                     w_state = S_FIN;
        end
      end
      S_FIN: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    w_mem_rd_en = (w_state == S_READ);
    w_mem_addr  = w_mem_rd_en ? w_addr : r_mem_addr;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_col       <= '0;
      r_shift     <= '0;
      r_bits      <= '0;
      r_tx_data   <= '0;
      r_tx_we     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_remain    <= w_remain;
      r_col       <= w_col;
      r_shift     <= w_shift;
      r_bits      <= w_bits;
      r_tx_data   <= w_tx_data;
      r_tx_we     <= w_tx_we;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_mem_rd_en <= w_mem_rd_en;
      r_mem_addr  <= w_mem_addr;
    end
  end

  assign o_mem_rd_en = r_mem_rd_en;
  assign o_mem_addr  = r_mem_addr;
  assign o_tx_data   = r_tx_data;
  assign o_tx_we     = r_tx_we;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
